// File: rtl/fwd_hazard_unit.sv
// Purpose : EX operand forwarding selects and load-use stall detection, using shadow EX/MEM/WB stages.
// Latency : fwd_a_o/fwd_b_o/stall_o are combinational; the shadow pipeline and stall_cnt_o update on clk_i.
// Backpres: stall_o holds ID (not consumed) and inserts an EX bubble; flush_i kills ID and EX and overrides stall.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   id_*_i                  decoded fields of the instruction currently in ID
//   flush_i                 taken branch: ID and EX instructions are discarded
//   fwd_a_o / fwd_b_o       EX operand mux selects: 2=EX/MEM, 1=MEM/WB, 0=register file
//   stall_o                 load-use hazard on the ID instruction
//   stall_cnt_o             saturating count of stalled cycles
module fwd_hazard_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_regwrite_i,
   input  logic        id_memread_i,
   input  logic        id_uses_rt_i,
   input  logic        flush_i,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic        stall_o,
   output logic [15:0] stall_cnt_o
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } ex_stage_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
   } wr_stage_t;

   localparam logic [1:0]  SEL_RF  = 2'd0;
   localparam logic [1:0]  SEL_WB  = 2'd1;
   localparam logic [1:0]  SEL_MEM = 2'd2;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   ex_stage_t   ex_q,  ex_d;
   wr_stage_t   mem_q, mem_d;
   wr_stage_t   wb_q,  wb_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        load_use;

   // A stage produces a value for src only if it really writes a non-zero register.
   function automatic logic produces(input wr_stage_t s, input logic [4:0] src);
      return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == src);
   endfunction

   // MEM is checked first: it holds the younger producer of the two.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      logic [1:0] sel;
      sel = SEL_RF;
      if (ex_q.valid) begin
         if (produces(mem_q, src))
            sel = SEL_MEM;
         else if (produces(wb_q, src))
            sel = SEL_WB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_o = fwd_sel(ex_q.rs);
      fwd_b_o = fwd_sel(ex_q.rt);
   end

   // Only a load in EX can cause a stall; every other producer is covered by forwarding.
   // While rst_i is high the EX shadow is held cleared, so stall_o drops with reset.
   always_comb begin
      load_use = id_valid_i && ex_q.valid && ex_q.memread && ex_q.regwrite &&
                 (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == id_rs_i) || (id_uses_rt_i && (ex_q.rd == id_rt_i)));
      stall_o  = load_use && !flush_i;
   end

   always_comb begin
      ex_d.valid    = id_valid_i;
      ex_d.rs       = id_rs_i;
      ex_d.rt       = id_rt_i;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_valid_i && id_regwrite_i;
      ex_d.memread  = id_valid_i && id_memread_i;
      mem_d.valid    = ex_q.valid;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      wb_d           = mem_q;
      stall_cnt_d    = stall_cnt_q;

      if (flush_i) begin
         // The EX instruction is killed too, so it must not reach MEM.
         ex_d  = '0;
         mem_d = '0;
      end else if (stall_o) begin
         ex_d = '0;
      end

      if (stall_o && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order: clk_i input 1 clock (rising edge); rst_i input 1 asynchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- id_valid_i input 1: ID-stage instruction valid
- id_rs_i input 5: ID source register A
- id_rt_i input 5: ID source register B
- id_rd_i input 5: ID destination register
- id_regwrite_i input 1: ID instruction writes rd
- id_memread_i input 1: ID instruction is a load
- id_uses_rt_i input 1: ID instruction reads rt
- flush_i input 1: branch taken, kill ID and EX instructions
REQ-003 The block SHALL have these outputs:
- fwd_a_o output 2: select for EX operand-A 4:1 mux
- fwd_b_o output 2: select for EX operand-B 4:1 mux
- stall_o output 1: hold PC and IF/ID, bubble into EX
- stall_cnt_o output 16: saturating count of stall cycles

Function
REQ-004 The block SHALL keep shadow pipeline stages:
- EX: valid, rs, rt, rd, regwrite, memread
- MEM: valid, rd, regwrite
- WB: valid, rd, regwrite
REQ-005 On each rising edge with stall_o=0 and flush_i=0, the block SHALL shift ID→EX→MEM→WB.
REQ-006 On each rising edge with stall_o=1, the block SHALL load a bubble (valid=0, regwrite=0, memread=0) into EX, shift EX→MEM and MEM→WB, and leave ID unconsumed.
REQ-007 On each rising edge with flush_i=1, the block SHALL load bubbles into EX and MEM (killing the ID and EX instructions) and shift MEM→WB.
REQ-008 The block SHALL drive stall_o=1 combinationally when all of the following hold:
- id_valid_i=1
- EX valid=1, EX memread=1, EX regwrite=1
- EX rd≠0
- EX rd==id_rs_i, or (id_uses_rt_i=1 and EX rd==id_rt_i)
REQ-009 flush_i=1 SHALL force stall_o=0 in the same cycle (flush wins).
REQ-010 fwd_a_o SHALL be derived combinationally from shadow registers only, for the EX instruction's rs:
- 2'd2 (EX/MEM result) if MEM valid, MEM regwrite, MEM rd≠0 and MEM rd==EX rs
- else 2'd1 (MEM/WB result) if the same conditions hold for the WB stage
- else 2'd0 (register file)
REQ-011 fwd_b_o SHALL follow the REQ-010 rules using EX rt.
REQ-012 MEM SHALL take priority over WB when both match (youngest producer wins).
REQ-013 fwd_a_o and fwd_b_o SHALL be 2'd0 whenever EX valid=0.
REQ-014 Encoding 2'd3 SHALL never be driven.
REQ-015 Register 0 SHALL never match as a producer.
REQ-016 stall_cnt_o SHALL increment by 1 on each rising edge where stall_o=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-017 Back-to-back loads to the same rd SHALL stall exactly one cycle per dependent consumer, never two.

Reset
REQ-018 While rst_i=1, regardless of clk_i, the block SHALL clear all shadow valid/regwrite/memread bits and all rd/rs/rt fields to 0.
REQ-019 While rst_i=1, the outputs SHALL read fwd_a_o=0, fwd_b_o=0, stall_o=0, stall_cnt_o=0.
REQ-020 Reset asserted mid-stall SHALL drop stall_o within the same cycle.
REQ-021 After reset deasserts, the first valid ID instruction SHALL see no producers.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add $3 (rd=3, regwrite) issued, then sub rs=3 on the next cycle: while sub is in EX, fwd_a_o=2'd2.
- add rd=3, one independent instruction, then or rs=3,rt=3: while or is in EX, fwd_a_o=fwd_b_o=2'd1.
- lw rd=5 (memread), then add rs=5: stall_o=1 for exactly one cycle; stall_cnt_o 0→1; after the bubble, add in EX sees fwd_a_o=2'd1.
- lw rd=5 with load-use consumer pending and flush_i=1 in the same cycle: stall_o=0; EX and MEM are bubbles next cycle; stall_cnt_o unchanged.
- Writer rd=0 followed by reader rs=0: fwd_a_o=2'd0, stall_o=0; writers rd=7 in both MEM and WB with reader rs=7: fwd_a_o=2'd2.
- Stall held continuously from stall_cnt_o=16'hFFFE: counts to 16'hFFFF and stays; rst_i pulsed asynchronously mid-stall: all outputs 0 immediately.
